serial_subtractor: RTL



---
 rtl/serial_sub_pkg.sv | 12 +
 rtl/fullsubtractor.sv | 17 +
 rtl/serial_subtractor.sv | 126 ++++++++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
// Shared constants for the bit-serial subtractor: FSM encoding and default operand width.
package serial_sub_pkg;

  localparam int unsigned SERIAL_SUB_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fullsubtractor.sv
// 1-bit full-subtractor cell (x - y - b_in), and/or/not logic only, purely combinational.
module fullsubtractor (
  input  logic x,
  input  logic y,
  input  logic b_in,
  output logic d,
  output logic b_out
);

  logic xy;

  // xor expressed as sum of products
  assign xy    = (x & ~y) | (~x & y);
  assign d     = (xy & ~b_in) | (~xy & b_in);
  assign b_out = (~x & y) | (~x & b_in) | (y & b_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock through a single fullsubtractor cell.
// Optional SERIAL_SUB_OVERFLOW_EN adds a signed-overflow output held alongside diff.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = SERIAL_SUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
`ifdef SERIAL_SUB_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_sh, b_sh, res_sh;
  logic               borrow;
  logic [CNT_W-1:0]   cnt;
  logic               load, step, finish;
  logic               cell_d, cell_b;

  fullsubtractor u_cell (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .b_in (borrow),
    .d    (cell_d),
    .b_out(cell_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_valid) begin
          load      = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) begin
          finish    = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand/result shift registers, borrow flop and bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
    end else if (load) begin
      a_sh   <= a;
      b_sh   <= b;
      borrow <= 1'b0;
      cnt    <= '0;
    end else if (step) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= {cell_d, res_sh[WIDTH-1:1]};
      borrow <= cell_b;
      cnt    <= cnt + CNT_W'(1);
    end
  end

  // Registered handshake and result hold; diff is captured from the last shift in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_ready <= 1'b1;
      done        <= 1'b0;
      diff        <= '0;
      borrow_out  <= 1'b0;
    end else begin
      start_ready <= (state_nxt == ST_IDLE);
      done        <= finish;
      if (finish) begin
        diff       <= {cell_d, res_sh[WIDTH-1:1]};
        borrow_out <= cell_b;
      end
    end
  end

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic a_msb, b_msb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (load) begin
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
      end
      // final cell output is the result MSB
      if (finish) overflow <= (a_msb != b_msb) && (cell_d != a_msb);
    end
  end
`endif

endmodule
